// File: rtl/ysyx_22051013_lsu_axi_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ysyx_22051013_lsu_axi_master_pkg                       |
// | Description : Shared types and constants for the LSU data-side AXI4  |
// |               master: FSM states, AXI field codes, data_size codes.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ysyx_22051013_lsu_axi_master_pkg;

   // Level at which rst is considered asserted across the pipeline
   localparam logic RST_ACTIVE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WREQ  = 3'd3,
      ST_WRESP = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   localparam logic [2:0] DSIZE_NONE = 3'b000;
   localparam logic [2:0] DSIZE_B    = 3'b011;
   localparam logic [2:0] DSIZE_H    = 3'b100;
   localparam logic [2:0] DSIZE_W    = 3'b101;
   localparam logic [2:0] DSIZE_D    = 3'b110;

   // LSU size code to AXI AxSIZE; "none" (and anything unknown) means a full doubleword
   function automatic logic [2:0] dsize_to_axsize(input logic [2:0] ds);
      logic [2:0] sz;
      case (ds)
         DSIZE_B:    sz = 3'd0;
         DSIZE_H:    sz = 3'd1;
         DSIZE_W:    sz = 3'd2;
         DSIZE_D:    sz = 3'd3;
         DSIZE_NONE: sz = 3'd3;
         default:    sz = 3'd3;
      endcase
      return sz;
   endfunction

   // True when the byte address is not naturally aligned to the access size
   function automatic logic misaligned(input logic [2:0] ds, input logic [2:0] lsb);
      logic m;
      case (ds)
         DSIZE_B: m = 1'b0;
         DSIZE_H: m = lsb[0];
         DSIZE_W: m = |lsb[1:0];
         default: m = |lsb;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22051013_axi_wr_join.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ysyx_22051013_axi_wr_join                              |
// | Description : Drives AWVALID/WVALID for one single-beat write and    |
// |               reports when both channels have handshaken, in any     |
// |               order or in the same cycle.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ysyx_22051013_axi_wr_join
   import ysyx_22051013_lsu_axi_master_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic awready,
   input  logic wready,
   output logic awvalid,
   output logic wvalid,
   output logic issued
);

   logic aw_done;
   logic w_done;
   logic aw_fire;
   logic w_fire;

   assign awvalid = active & ~aw_done;
   assign wvalid  = active & ~w_done;
   assign aw_fire = awvalid & awready;
   assign w_fire  = wvalid & wready;
   assign issued  = active & (aw_done | aw_fire) & (w_done | w_fire);

   // Remember which channel has already completed; cleared once the pair is issued
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE || !active || issued) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_fire) aw_done <= 1'b1;
         if (w_fire)  w_done  <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_22051013_lsu_axi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ysyx_22051013_lsu_axi_master                           |
// | Description : Converts one LSU load/store into a single-beat AXI4    |
// |               transaction and returns data/completion to the LSU     |
// |               with a valid/ready handshake.                          |
// |               Optional: YSYX_22051013_DMEM_ALIGN_CHK_EN rejects      |
// |               misaligned requests locally with bus_err.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ysyx_22051013_lsu_axi_master
   import ysyx_22051013_lsu_axi_master_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int AXI_ID = 1
) (
   input  logic              clk,
   input  logic              rst,
   // LSU side
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] data_pc,
   input  logic [DATA_W-1:0] data_o,
   input  logic [7:0]        wlen,
   input  logic [2:0]        data_size,
   input  logic              core_ready,
   output logic [DATA_W-1:0] data_temp,
   output logic              data_valid,
   output logic              bus_err,
   // AR
   output logic              arvalid,
   input  logic              arready,
   output logic [ADDR_W-1:0] araddr,
   output logic [ID_W-1:0]   arid,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   // R
   input  logic              rvalid,
   output logic              rready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [ID_W-1:0]   rid,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   // AW
   output logic              awvalid,
   input  logic              awready,
   output logic [ADDR_W-1:0] awaddr,
   output logic [ID_W-1:0]   awid,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   // W
   output logic              wvalid,
   input  logic              wready,
   output logic [DATA_W-1:0] wdata,
   output logic [7:0]        wstrb,
   output logic              wlast,
   // B
   input  logic              bvalid,
   output logic              bready,
   input  logic [ID_W-1:0]   bid,
   input  logic [1:0]        bresp
);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [7:0]        wstrb_q;
   logic [2:0]        axsize_q;
   logic              wr_issued;
   logic              req_misaligned;
   logic              unused_ok;

   // Single-beat transfers only; IDs, RLAST and BID carry no information here
   assign unused_ok = ^{rid, rlast, bid};

`ifdef YSYX_22051013_DMEM_ALIGN_CHK_EN
   assign req_misaligned = misaligned(data_size, data_pc[2:0]);
`else
   assign req_misaligned = 1'b0;
`endif

   assign arvalid    = (state == ST_RADDR);
   assign rready     = (state == ST_RDATA);
   assign bready     = (state == ST_WRESP);
   assign data_valid = (state == ST_RESP);

   assign araddr  = addr_q;
   assign arid    = ID_W'(AXI_ID);
   assign arlen   = 8'd0;
   assign arsize  = axsize_q;
   assign arburst = BURST_INCR;

   assign awaddr  = addr_q;
   assign awid    = ID_W'(AXI_ID);
   assign awlen   = 8'd0;
   assign awsize  = axsize_q;
   assign awburst = BURST_INCR;

   assign wdata = wdata_q;
   assign wstrb = wstrb_q;
   assign wlast = 1'b1;

   ysyx_22051013_axi_wr_join u_wr_join (
      .clk     (clk),
      .rst     (rst),
      .active  (state == ST_WREQ),
      .awready (awready),
      .wready  (wready),
      .awvalid (awvalid),
      .wvalid  (wvalid),
      .issued  (wr_issued)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) state <= ST_IDLE;
      else                   state <= state_nxt;
   end

   // Next-state logic; loads take priority over a simultaneous store
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (re)      state_nxt = req_misaligned ? ST_RESP : ST_RADDR;
            else if (we) state_nxt = req_misaligned ? ST_RESP : ST_WREQ;
         end
         ST_RADDR: if (arready)    state_nxt = ST_RDATA;
         ST_RDATA: if (rvalid)     state_nxt = ST_RESP;
         ST_WREQ:  if (wr_issued)  state_nxt = ST_WRESP;
         ST_WRESP: if (bvalid)     state_nxt = ST_RESP;
         ST_RESP:  if (core_ready) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   // Request latches and response capture; response fields stay frozen in RESP
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         axsize_q  <= '0;
         data_temp <= '0;
         bus_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (re || we) begin
                  addr_q    <= data_pc;
                  axsize_q  <= dsize_to_axsize(data_size);
                  data_temp <= '0;
                  bus_err   <= req_misaligned;
                  if (!re) begin
                     wdata_q <= data_o;
                     wstrb_q <= wlen;
                  end
               end
            end
            ST_RDATA: begin
               if (rvalid) begin
                  data_temp <= rdata;
                  bus_err   <= (rresp != RESP_OKAY);
               end
            end
            ST_WRESP: begin
               if (bvalid) begin
                  data_temp <= '0;
                  bus_err   <= (bresp != RESP_OKAY);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/ysyx_22051013_lsu_axi_master.md
Name: ysyx_22051013_lsu_axi_master

Overview:
Data-side AXI4 master that sits directly downstream of the pipeline's load/store unit. It converts one LSU load or store request into a single-beat AXI4 transaction (LEN=0, INCR). For loads it returns raw 64-bit read data to the LSU; for stores it returns a completion. It holds at most one outstanding transaction and stalls the LSU through a valid/ready response handshake.

Parameters:
- ADDR_W, 64, request/AXI address width
- DATA_W, 64, data width; fixed 8-byte strobe
- ID_W, 4, AXI ID width
- AXI_ID, 1, constant ID driven on ARID/AWID

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- re  in  1  load request (level, from LSU)
- we  in  1  store request (level, from LSU)
- data_pc  in  ADDR_W  request address; loads arrive 8-byte aligned
- data_o  in  DATA_W  store data, already lane-shifted
- wlen  in  8  store byte strobe
- data_size  in  3  011=B, 100=H, 101=W, 110=D, 000=none
- core_ready  in  1  LSU accepts the response this cycle
- data_temp  out  DATA_W  read data (load) / 0 (store)
- data_valid  out  1  response valid; held until core_ready
- bus_err  out  1  qualifies data_valid: RRESP/BRESP != OKAY
- arvalid/arready/araddr/arid/arlen/arsize/arburst: AXI4 AR channel
- rvalid/rready/rdata/rid/rresp/rlast: AXI4 R channel
- awvalid/awready/awaddr/awid/awlen/awsize/awburst: AXI4 AW channel
- wvalid/wready/wdata/wstrb/wlast: AXI4 W channel
- bvalid/bready/bid/bresp: AXI4 B channel

Behaviour:
- Reset values: all valid/ready outputs 0, data_temp 0, data_valid 0, bus_err 0, state IDLE. Reset mid-transaction drops it immediately; no AXI handshake is completed.
- States: IDLE, RADDR, RDATA, WREQ, WRESP, RESP.
- IDLE:
  - re=1 → latch address and size; go to RADDR.
  - else we=1 → latch address, data, wlen and size; go to WREQ.
  - re and we both 1 (illegal): re wins.
  - Requests are sampled only in IDLE. Earliest arvalid/awvalid is the cycle after the request.
- RADDR: arvalid=1 with latched fields, stable until arready. On arvalid&arready → RDATA.
- RDATA: rready=1. On rvalid, capture rdata and bus_err=(rresp!=0); go to RESP.
- WREQ: awvalid and wvalid both asserted; each drops independently on its own handshake (aw_done, w_done flags). AW and W may complete in the same or different cycles in either order. When both are done → WRESP.
- WRESP: bready=1. On bvalid, bus_err=(bresp!=0) and data_temp=0; go to RESP.
- RESP: data_valid=1; data_temp and bus_err stable. On core_ready → IDLE (data_valid low next cycle). A new request can be issued the cycle after returning to IDLE.
- Minimum load latency with zero-wait slave: request cycle → RADDR → RDATA → RESP = data_valid 3 cycles after request.
- Fixed AXI fields:
  - axsize = data_size-3 (B=0, H=1, W=2, D=3); data_size=000 with a request is treated as D.
  - arlen/awlen=0, burst=INCR(01), wlast=1.
  - araddr is the latched aligned address; awaddr is the latched byte address.
- rlast and rid/bid are ignored. An unexpected rvalid/bvalid in other states is not acknowledged (ready stays low).

Optional Feature:
- Macro YSYX_22051013_DMEM_ALIGN_CHK_EN.
- Defined: in IDLE, a request whose address is not naturally aligned to data_size (H: addr[0]; W: addr[1:0]; D: addr[2:0] nonzero) is not issued on AXI. The block goes directly to RESP with bus_err=1 and data_temp=0, so data_valid is asserted 1 cycle after the request.
- Undefined: no check; all requests go to AXI unchanged.

Decomposition:
- Shared package/define file:
  - state encoding constants
  - AXI burst/resp constants (INCR, OKAY)
  - data_size encodings
  - reset-active level macro already used by the pipeline
- One sub-module is natural: ysyx_22051013_axi_wr_join, tracking aw_done/w_done and producing the "write issued" condition.
- The top module holds the FSM, request latches and the read path.

Test Plan:
- Load, zero-wait slave: re=1, data_pc=0x8000_0008, data_size=110 → araddr=0x8000_0008, arsize=3; rdata=0x1122334455667788 → data_valid=1 three cycles after the request, data_temp=0x1122334455667788, bus_err=0.
- Store with AW before W: we=1, addr=0x8000_0013, wlen=0x08, data_size=011, awready at cycle 1, wready at cycle 4 → awvalid falls after cycle 1, wvalid held until cycle 4, awsize=0, wstrb=0x08; bvalid OKAY → data_valid=1, data_temp=0.
- Response backpressure: core_ready=0 for 5 cycles in RESP → data_valid and data_temp held constant; no new arvalid even with re=1. core_ready=1 → IDLE next cycle.
- Slave error: rresp=2'b10 on a W load → data_valid=1 with bus_err=1.
- Reset mid-transaction: rst=1 while in RDATA → next cycle all valids 0, state IDLE; a subsequent load completes normally.
- With YSYX_22051013_DMEM_ALIGN_CHK_EN defined: W load at 0x8000_0002 → no arvalid ever asserted; data_valid=1, bus_err=1 one cycle after the request.
